pila_retorno: RTL and testbench

- Return-address stack (LIFO) that answers the push/pop commands issued by the control unit during call/return instructions.
- On push it stores the return PC supplied by the datapath.
- On pop it presents the saved PC so the PC mux (selected by s_pila) can load it in the same cycle.
- Tracks depth and records sticky overflow/underflow errors for debug and for the test bench.

---
 rtl/pila_retorno.sv | 125 ++++++++++++
 tb/tb_pila_retorno.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pila_retorno.sv
// rtl/pila_retorno.sv - return-address stack (LIFO) for call/return PC handling
//
// Purpose:
//   Stores return PCs pushed by the control unit on a call and presents the
//   most recent one combinationally on 'top' so the PC mux can load it in the
//   same cycle as the pop. Tracks depth and keeps sticky overflow/underflow
//   flags for debug.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset (highest priority)
//   push       in   store pc_in on this edge
//   pop        in   discard top entry on this edge
//   pc_in      in   [AW]  return address to save (stored unmodified)
//   clr_err    in   synchronous clear of the sticky flags
//   top        out  [AW]  top entry, 0 when empty
//   depth      out  [CW]  number of valid entries 0..DEPTH
//   empty      out  depth == 0
//   full       out  depth == DEPTH
//   overflow   out  sticky, push while full
//   underflow  out  sticky, pop while empty

module pila_retorno #(
    parameter int DEPTH = 8,
    parameter int AW    = 10,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] pc_in,
    input  logic          clr_err,
    output logic [AW-1:0] top,
    output logic [CW-1:0] depth,
    output logic          empty,
    output logic          full,
    output logic          overflow,
    output logic          underflow
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0] mem_q [DEPTH];
    logic [CW-1:0] sp_q, sp_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;

    logic          wr_en;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;

    // sp is the next free slot; the top entry sits at sp-1. When sp==0 the
    // index wraps but 'top' is forced to zero so the value is never seen.
    assign rd_idx = IW'(sp_q - CW'(1));

    assign empty     = (sp_q == '0);
    assign full      = (sp_q == CW'(DEPTH));
    assign depth     = sp_q;
    assign top       = empty ? '0 : mem_q[rd_idx];
    assign overflow  = ovf_q;
    assign underflow = unf_q;

    always_comb begin
        sp_d   = sp_q;
        wr_en  = 1'b0;
        wr_idx = IW'(sp_q);
        // clr_err is applied first so an error raised on the same edge wins.
        ovf_d  = clr_err ? 1'b0 : ovf_q;
        unf_d  = clr_err ? 1'b0 : unf_q;

        case ({push, pop})
            2'b10: begin
                if (full) begin
                    ovf_d = 1'b1;
                end else begin
                    wr_en = 1'b1;
                    sp_d  = sp_q + CW'(1);
                end
            end
            2'b01: begin
                if (empty) begin
                    unf_d = 1'b1;
                end else begin
                    sp_d = sp_q - CW'(1);
                end
            end
            2'b11: begin
                if (empty) begin
                    // Nothing to pop: record the underflow, still accept the push.
                    wr_en  = 1'b1;
                    wr_idx = '0;
                    sp_d   = CW'(1);
                    unf_d  = 1'b1;
                end else begin
                    // Replace the top entry in place.
                    wr_en  = 1'b1;
                    wr_idx = rd_idx;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Storage is not reset; only writes are suppressed while reset is high.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            mem_q[wr_idx] <= pc_in;
        end
    end

endmodule

// File: tb/tb_pila_retorno.sv
// tb/tb_pila_retorno.sv - self-checking bench for pila_retorno with queue model
module tb_pila_retorno;

    localparam int DEPTH = 8;
    localparam int AW    = 10;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic [AW-1:0] pc_in = '0;
    logic          clr_err = 1'b0;
    logic [AW-1:0] top;
    logic [CW-1:0] depth;
    logic          empty, full, overflow, underflow;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    pila_retorno #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .pc_in(pc_in),
        .clr_err(clr_err), .top(top), .depth(depth), .empty(empty),
        .full(full), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Behavioural model: a plain queue whose back is the top of stack.
    int unsigned mq[$];
    bit m_ovf = 1'b0;
    bit m_unf = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (clr_err) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
            if (push && pop) begin
                if (mq.size() == 0) begin
                    mq.push_back(int'(pc_in));
                    m_unf = 1'b1;
                end else begin
                    mq[mq.size() - 1] = int'(pc_in);
                end
            end else if (push) begin
                if (mq.size() == DEPTH) m_ovf = 1'b1;
                else mq.push_back(int'(pc_in));
            end else if (pop) begin
                if (mq.size() == 0) m_unf = 1'b1;
                else void'(mq.pop_back());
            end
        end
    end

    function automatic int m_top();
        return (mq.size() == 0) ? 0 : int'(mq[mq.size() - 1]);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_top",       int'(top),       m_top());
            check("cyc_depth",     int'(depth),     mq.size());
            check("cyc_empty",     int'(empty),     int'(mq.size() == 0));
            check("cyc_full",      int'(full),      int'(mq.size() == DEPTH));
            check("cyc_overflow",  int'(overflow),  int'(m_ovf));
            check("cyc_underflow", int'(underflow), int'(m_unf));
        end
    end

    // Apply one cycle of inputs at the falling edge; return 1 time unit after
    // the rising edge so state can be inspected.
    task automatic tick(input bit p, input bit o, input int pc, input bit c, input bit r);
        @(negedge clk);
        push    = p;
        pop     = o;
        pc_in   = AW'(pc);
        clr_err = c;
        reset   = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        tick(0, 0, 0, 0, 0);
    endtask

    initial begin
        // Reset then idle
        tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 1);
        chk_en = 1'b1;
        check("rst_depth", int'(depth), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_full",  int'(full), 0);
        check("rst_top",   int'(top), 0);
        check("rst_ovf",   int'(overflow), 0);
        check("rst_unf",   int'(underflow), 0);
        idle();

        // Three pushes then three pops
        tick(1, 0, 'h011, 0, 0);
        tick(1, 0, 'h022, 0, 0);
        tick(1, 0, 'h033, 0, 0);
        check("p3_depth", int'(depth), 3);
        check("p3_top",   int'(top), 'h033);
        tick(0, 1, 0, 0, 0);
        check("pop1_top", int'(top), 'h022);
        tick(0, 1, 0, 0, 0);
        check("pop2_top", int'(top), 'h011);
        tick(0, 1, 0, 0, 0);
        check("pop3_depth", int'(depth), 0);
        check("pop3_top",   int'(top), 0);
        check("pop3_flags", int'({overflow, underflow}), 0);

        // Overflow
        for (int i = 0; i < DEPTH; i++) tick(1, 0, 'h100 + i, 0, 0);
        check("of_full", int'(full), 1);
        check("of_top",  int'(top), 'h107);
        tick(1, 0, 'h3FF, 0, 0);
        check("of_ovf",   int'(overflow), 1);
        check("of_depth", int'(depth), 8);
        check("of_top2",  int'(top), 'h107);
        for (int i = 0; i < DEPTH; i++) begin
            check("of_pop_top", int'(top), 'h107 - i);
            tick(0, 1, 0, 0, 0);
        end
        check("of_empty", int'(empty), 1);
        tick(0, 0, 0, 1, 0);
        check("of_clr", int'(overflow), 0);

        // Underflow and clear
        tick(0, 1, 0, 0, 0);
        check("uf_set",   int'(underflow), 1);
        check("uf_depth", int'(depth), 0);
        check("uf_top",   int'(top), 0);
        tick(0, 0, 0, 1, 0);
        check("uf_clr", int'(underflow), 0);
        tick(0, 1, 0, 1, 0);
        check("uf_clr_vs_err", int'(underflow), 1);
        tick(0, 0, 0, 1, 0);

        // Simultaneous push+pop
        tick(1, 0, 'h050, 0, 0);
        tick(1, 1, 'h060, 0, 0);
        check("pp_depth", int'(depth), 1);
        check("pp_top",   int'(top), 'h060);
        check("pp_unf",   int'(underflow), 0);
        tick(0, 1, 0, 0, 0);
        tick(1, 1, 'h070, 0, 0);
        check("ppe_depth", int'(depth), 1);
        check("ppe_top",   int'(top), 'h070);
        check("ppe_unf",   int'(underflow), 1);

        // Reset mid-operation (underflow still set from above)
        for (int i = 0; i < 5; i++) tick(1, 0, 'h200 + i, 0, 0);
        tick(1, 0, 'h2AA, 0, 1);
        check("mr_depth", int'(depth), 0);
        check("mr_empty", int'(empty), 1);
        check("mr_flags", int'({overflow, underflow}), 0);
        check("mr_top",   int'(top), 0);
        idle();

        // Randomized phases alternating push-heavy and pop-heavy bias
        for (int ph = 0; ph < 40; ph++) begin
            int pw;
            pw = (ph % 2 == 0) ? 70 : 25;
            for (int k = 0; k < 50; k++) begin
                bit p, o, c, r;
                p = ($urandom_range(99) < pw);
                o = ($urandom_range(99) < (95 - pw));
                c = ($urandom_range(15) == 0);
                r = ($urandom_range(199) == 0);
                tick(p, o, int'($urandom_range(1023)), c, r);
            end
        end
        idle();
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
